// File: rtl/systolic_tile_if.sv
// Stream bundle for systolic_tile: job control, X/W operand streams, result stream.
// The `sat` signal exists only when SYSTOLIC_SAT_EN is defined.
interface systolic_tile_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int NBITS = 16,
  parameter int DEPTH = 16
);
  localparam int KW = $clog2(DEPTH + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int OW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                  start;
  logic [KW-1:0]         k_len;
  logic                  busy;
  logic                  x_val;
  logic                  x_rdy;
  logic [ROWS*NBITS-1:0] x_data;
  logic                  w_val;
  logic                  w_rdy;
  logic [COLS*NBITS-1:0] w_data;
  logic                  out_val;
  logic                  out_rdy;
  logic [NBITS-1:0]      out_data;
  logic [RW-1:0]         out_row;
  logic [OW-1:0]         out_col;
  logic                  out_last;
`ifdef SYSTOLIC_SAT_EN
  logic                  sat;
`endif

  modport master (
    output start, k_len,
    output x_val, x_data,
    output w_val, w_data,
    output out_rdy,
    input  busy, x_rdy, w_rdy,
    input  out_val, out_data,
    input  out_row, out_col, out_last
`ifdef SYSTOLIC_SAT_EN
    , input sat
`endif
  );

  modport slave (
    input  start, k_len,
    input  x_val, x_data,
    input  w_val, w_data,
    input  out_rdy,
    output busy, x_rdy, w_rdy,
    output out_val, out_data,
    output out_row, out_col, out_last
`ifdef SYSTOLIC_SAT_EN
    , output sat
`endif
  );
endinterface

// File: rtl/systolic_tile.sv
// Output-stationary systolic matmul tile: C = X * W, streamed operands, drained results.
// Optional SYSTOLIC_SAT_EN: saturating arithmetic and a sticky `sat` flag.
module systolic_tile #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int NBITS = 16,
  parameter int DBITS = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  systolic_tile_if.slave bus
);
  localparam int KW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + ROWS + COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int OW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW = 2 * NBITS;

`ifdef SYSTOLIC_SAT_EN
  localparam int FW = NBITS + 1;
  localparam logic signed [PW-1:0] PMAX =
    {{(NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
  localparam logic signed [PW-1:0] PMIN =
    {{(NBITS+1){1'b1}}, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] NMAX =
    {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [NBITS-1:0] NMIN =
    {1'b1, {(NBITS-1){1'b0}}};
`else
  localparam int FW = NBITS;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN
  } state_t;

  state_t        state_q;
  logic [KW-1:0] klen_q;
  logic [KW-1:0] xcnt_q;
  logic [KW-1:0] wcnt_q;
  logic [CW-1:0] cnt_q;
  logic          x_rdy_q;
  logic          w_rdy_q;
  logic          out_val_q;
  logic          out_last_q;
  logic [RW-1:0] row_q;
  logic [OW-1:0] col_q;

  logic signed [NBITS-1:0] xmem_q [ROWS][DEPTH];
  logic signed [NBITS-1:0] wmem_q [COLS][DEPTH];
  logic signed [NBITS-1:0] xp_q   [ROWS][COLS];
  logic signed [NBITS-1:0] wp_q   [ROWS][COLS];
  logic signed [NBITS-1:0] acc_q  [ROWS][COLS];

  logic signed [NBITS-1:0] xe     [ROWS];
  logic signed [NBITS-1:0] we     [COLS];
  logic signed [NBITS-1:0] xin    [ROWS][COLS];
  logic signed [NBITS-1:0] win    [ROWS][COLS];
  logic        [FW-1:0]    mac_d  [ROWS][COLS];

  logic [KW-1:0] kl_d;
  logic [CW-1:0] last_c;
  logic          job_go;
  logic          x_acc;
  logic          w_acc;

`ifdef SYSTOLIC_SAT_EN
  logic sat_q [ROWS][COLS];
  logic sat_any;
`endif

  // One MAC step: full product, shift by DBITS, add to accumulator.
  function automatic logic [FW-1:0] mac(
    input logic signed [NBITS-1:0] a,
    input logic signed [NBITS-1:0] x,
    input logic signed [NBITS-1:0] w
  );
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    sh;
    logic        [NBITS-1:0] p;
`ifdef SYSTOLIC_SAT_EN
    logic        [NBITS:0]   s;
    logic                    ov;
`endif
    prod = PW'(x) * PW'(w);
    sh   = prod >>> DBITS;
`ifdef SYSTOLIC_SAT_EN
    ov = 1'b0;
    if (sh > PMAX) begin
      p  = NMAX;
      ov = 1'b1;
    end else if (sh < PMIN) begin
      p  = NMIN;
      ov = 1'b1;
    end else begin
      p = sh[NBITS-1:0];
    end
    s = {a[NBITS-1], a} + {p[NBITS-1], p};
    if (s[NBITS] != s[NBITS-1])
      mac = {1'b1, s[NBITS] ? NMIN : NMAX};
    else
      mac = {ov, s[NBITS-1:0]};
`else
    p   = sh[NBITS-1:0];
    mac = a + p;
`endif
  endfunction

  assign kl_d = (bus.k_len > KW'(DEPTH)) ?
                KW'(DEPTH) : bus.k_len;
  assign last_c = CW'(klen_q) + CW'(ROWS + COLS - 3);
  assign job_go = (state_q == IDLE) && bus.start;
  assign x_acc  = (state_q == LOAD) && x_rdy_q && bus.x_val;
  assign w_acc  = (state_q == LOAD) && w_rdy_q && bus.w_val;

  assign bus.busy     = (state_q != IDLE);
  assign bus.x_rdy    = x_rdy_q;
  assign bus.w_rdy    = w_rdy_q;
  assign bus.out_val  = out_val_q;
  assign bus.out_last = out_last_q;
  assign bus.out_row  = row_q;
  assign bus.out_col  = col_q;
  assign bus.out_data = acc_q[row_q][col_q];

  // Control FSM: load counters, compute cycle counter, drain cursor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      klen_q     <= '0;
      xcnt_q     <= '0;
      wcnt_q     <= '0;
      cnt_q      <= '0;
      x_rdy_q    <= 1'b0;
      w_rdy_q    <= 1'b0;
      out_val_q  <= 1'b0;
      out_last_q <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            klen_q <= kl_d;
            xcnt_q <= '0;
            wcnt_q <= '0;
            cnt_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
            if (kl_d == '0) begin
              state_q    <= DRAIN;
              out_val_q  <= 1'b1;
              out_last_q <= (ROWS * COLS == 1);
            end else begin
              state_q <= LOAD;
              x_rdy_q <= 1'b1;
              w_rdy_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (x_acc) begin
            xcnt_q <= xcnt_q + KW'(1);
            if (xcnt_q + KW'(1) == klen_q)
              x_rdy_q <= 1'b0;
          end
          if (w_acc) begin
            wcnt_q <= wcnt_q + KW'(1);
            if (wcnt_q + KW'(1) == klen_q)
              w_rdy_q <= 1'b0;
          end
          if (xcnt_q == klen_q && wcnt_q == klen_q)
            state_q <= COMPUTE;
        end
        COMPUTE: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == last_c) begin
            state_q    <= DRAIN;
            out_val_q  <= 1'b1;
            out_last_q <= (ROWS * COLS == 1);
          end
        end
        DRAIN: begin
          if (out_val_q && bus.out_rdy) begin
            if (out_last_q) begin
              state_q    <= IDLE;
              out_val_q  <= 1'b0;
              out_last_q <= 1'b0;
              row_q      <= '0;
              col_q      <= '0;
            end else if (col_q == OW'(COLS - 1)) begin
              col_q      <= '0;
              row_q      <= row_q + RW'(1);
              out_last_q <= (COLS == 1) &&
                (row_q + RW'(1) == RW'(ROWS - 1));
            end else begin
              col_q      <= col_q + OW'(1);
              out_last_q <= (row_q == RW'(ROWS - 1)) &&
                (col_q + OW'(1) == OW'(COLS - 1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand FIFO storage; occupancy is the beat counters, flushed by reset.
  always_ff @(posedge clk) begin
    if (x_acc)
      for (int i = 0; i < ROWS; i++)
        xmem_q[i][AW'(xcnt_q)] <= bus.x_data[i*NBITS +: NBITS];
    if (w_acc)
      for (int j = 0; j < COLS; j++)
        wmem_q[j][AW'(wcnt_q)] <= bus.w_data[j*NBITS +: NBITS];
  end

  // Skewed edge inputs: row i / column j lag the cycle counter by i / j.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      xe[i] = '0;
      if (cnt_q >= CW'(i) &&
          cnt_q - CW'(i) < CW'(klen_q))
        xe[i] = xmem_q[i][AW'(cnt_q - CW'(i))];
    end
    for (int j = 0; j < COLS; j++) begin
      we[j] = '0;
      if (cnt_q >= CW'(j) &&
          cnt_q - CW'(j) < CW'(klen_q))
        we[j] = wmem_q[j][AW'(cnt_q - CW'(j))];
    end
  end

  // PE inputs come from the array edge or the neighbour's pipeline register.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      xin[i][0] = xe[i];
      for (int j = 1; j < COLS; j++)
        xin[i][j] = xp_q[i][j-1];
    end
    for (int j = 0; j < COLS; j++) begin
      win[0][j] = we[j];
      for (int i = 1; i < ROWS; i++)
        win[i][j] = wp_q[i-1][j];
    end
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        mac_d[i][j] = mac(acc_q[i][j], xin[i][j], win[i][j]);
  end

  // PE array state: cleared on start, advanced only while computing.
  always_ff @(posedge clk) begin
    if (rst || job_go) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          xp_q[i][j]  <= '0;
          wp_q[i][j]  <= '0;
          acc_q[i][j] <= '0;
`ifdef SYSTOLIC_SAT_EN
          sat_q[i][j] <= 1'b0;
`endif
        end
    end else if (state_q == COMPUTE) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          xp_q[i][j]  <= xin[i][j];
          wp_q[i][j]  <= win[i][j];
          acc_q[i][j] <= mac_d[i][j][NBITS-1:0];
`ifdef SYSTOLIC_SAT_EN
          sat_q[i][j] <= sat_q[i][j] | mac_d[i][j][NBITS];
`endif
        end
    end
  end

`ifdef SYSTOLIC_SAT_EN
  // Any PE that ever clipped in this job raises sat.
  always_comb begin
    sat_any = 1'b0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        sat_any = sat_any | sat_q[i][j];
  end

  assign bus.sat = sat_any;
`endif

endmodule

// File: tb/tb_systolic_tile.sv
// Directed bench for systolic_tile: 4x4 tile for the main jobs,
// plus a 2x3 tile for the rectangular case.
module tb_systolic_tile;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  systolic_tile_if #(
    .ROWS(4), .COLS(4), .NBITS(16), .DEPTH(16)
  ) b0 ();
  systolic_tile_if #(
    .ROWS(2), .COLS(3), .NBITS(16), .DEPTH(4)
  ) b1 ();

  systolic_tile #(
    .ROWS(4), .COLS(4), .NBITS(16), .DBITS(8), .DEPTH(16)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  systolic_tile #(
    .ROWS(2), .COLS(3), .NBITS(16), .DBITS(8), .DEPTH(4)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] xs   [16];
  logic [63:0] ws   [16];
  logic [15:0] expv [16];
  logic [15:0] e1   [6] = '{16'h0100, 16'h0200, 16'h0600,
                            16'hFF80, 16'hFF00, 16'hFD00};
  bit xdone;
  bit wdone;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rst_checks(string p);
    check({p, "_busy"},  b0.busy, 0);
    check({p, "_xrdy"},  b0.x_rdy, 0);
    check({p, "_wrdy"},  b0.w_rdy, 0);
    check({p, "_oval"},  b0.out_val, 0);
    check({p, "_olast"}, b0.out_last, 0);
    check({p, "_odata"}, b0.out_data, 0);
    check({p, "_orow"},  b0.out_row, 0);
    check({p, "_ocol"},  b0.out_col, 0);
  endtask

  task automatic xstream(int k, bit gap);
    int n = 0;
    int g = 0;
    bit go;
    while (n < k && g < 400) begin
      go = !gap || ($urandom_range(0, 2) != 0);
      b0.x_val  = go;
      b0.x_data = go ? xs[n] : '0;
      go = go && b0.x_rdy;
      @(negedge clk);
      if (go) n++;
      g++;
    end
    if (n < k) check("x_timeout", n, k);
    xdone = 1;
    check("x_rdy_done", b0.x_rdy, 0);
    b0.x_val  = gap;
    b0.x_data = 64'hDEAD_BEEF_DEAD_BEEF;
    while (gap && !wdone && g < 400) begin
      check("x_rdy_extra", b0.x_rdy, 0);
      @(negedge clk);
      g++;
    end
    b0.x_val = 0;
  endtask

  task automatic wstream(int k, bit gap);
    int n = 0;
    int g = 0;
    bit go;
    while (gap && !xdone && g < 400) begin
      check("w_rdy_wait", b0.w_rdy, 1);
      @(negedge clk);
      g++;
    end
    while (n < k && g < 400) begin
      go = !gap || ($urandom_range(0, 2) != 0);
      b0.w_val  = go;
      b0.w_data = go ? ws[n] : '0;
      go = go && b0.w_rdy;
      @(negedge clk);
      if (go) n++;
      g++;
    end
    if (n < k) check("w_timeout", n, k);
    wdone = 1;
    b0.w_val = 0;
    check("w_rdy_done", b0.w_rdy, 0);
  endtask

  task automatic drain(bit bp, int exp_lat);
    int n = 0;
    int g = 0;
    int lat = 1;
    bit seen = 0;
    bit stall = 0;
    bit sent = 0;
    logic [15:0] held = '0;
    while (n < 16 && g < 600) begin
      if (!seen && b0.out_val) begin
        seen = 1;
        if (exp_lat > 0) check("latency", lat, exp_lat);
      end
      if (stall) begin
        check("hold_val", b0.out_val, 1);
        check("hold_data", b0.out_data, held);
      end
      b0.out_rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      b0.start = 0;
      if (bp && b0.out_val && !b0.out_rdy && !sent) begin
        b0.start = 1;
        b0.k_len = 5'd0;
        sent = 1;
      end
      stall = b0.out_val && !b0.out_rdy;
      held = b0.out_data;
      if (b0.out_val && b0.out_rdy) begin
        check("data", b0.out_data, expv[n]);
        check("row", b0.out_row, n / 4);
        check("col", b0.out_col, n % 4);
        check("last", b0.out_last, n == 15);
        n++;
      end
      @(negedge clk);
      lat++;
      g++;
    end
    b0.out_rdy = 0;
    b0.start = 0;
    if (n < 16) check("drain_timeout", n, 16);
    check("idle_after", b0.busy, 0);
    check("oval_after", b0.out_val, 0);
  endtask

  task automatic run_job(int k, bit skew, bit bp, int lat);
    xdone = 0;
    wdone = 0;
    @(negedge clk);
    b0.start = 1;
    b0.k_len = 5'(k);
    @(negedge clk);
    b0.start = 0;
    check("busy_start", b0.busy, 1);
    check("x_rdy_rise", b0.x_rdy, k > 0);
    check("w_rdy_rise", b0.w_rdy, k > 0);
    fork
      xstream(k, skew);
      wstream(k, skew);
      drain(bp, lat);
    join
  endtask

  task automatic load_identity();
    for (int c = 0; c < 4; c++) begin
      xs[c] = '0;
      ws[c] = '0;
      for (int i = 0; i < 4; i++) begin
        xs[c][i*16 +: 16] = (i == c) ? 16'h0100 : 16'h0000;
        ws[c][i*16 +: 16] = 16'((4 * c + i) << 8);
      end
    end
    for (int n = 0; n < 16; n++)
      expv[n] = 16'(n << 8);
  endtask

  initial begin
    int n;
    int g;
    b0.start = 0; b0.k_len = '0;
    b0.x_val = 0; b0.x_data = '0;
    b0.w_val = 0; b0.w_data = '0;
    b0.out_rdy = 0;
    b1.start = 0; b1.k_len = '0;
    b1.x_val = 0; b1.x_data = '0;
    b1.w_val = 0; b1.w_data = '0;
    b1.out_rdy = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst_checks("rst");
    rst = 0;

    load_identity();
    run_job(4, 0, 0, 16);
`ifdef SYSTOLIC_SAT_EN
    check("sat_clear", b0.sat, 0);
`endif
    run_job(4, 1, 0, 0);
    run_job(4, 0, 1, 16);

    for (int c = 0; c < 4; c++) begin
      xs[c] = {4{16'h7F00}};
      ws[c] = {4{16'h7F00}};
    end
    for (int i = 0; i < 16; i++) begin
`ifdef SYSTOLIC_SAT_EN
      expv[i] = 16'h7FFF;
`else
      expv[i] = 16'h0200;
`endif
    end
    run_job(2, 0, 0, 12);
`ifdef SYSTOLIC_SAT_EN
    check("sat_set", b0.sat, 1);
`endif

    xdone = 0;
    wdone = 0;
    @(negedge clk);
    b0.start = 1;
    b0.k_len = 5'd4;
    @(negedge clk);
    b0.start = 0;
    fork
      xstream(4, 0);
      wstream(4, 0);
    join
    repeat (3) @(negedge clk);
    check("mid_busy", b0.busy, 1);
    rst = 1;
    @(negedge clk);
    rst_checks("abort");
    rst = 0;

    for (int i = 0; i < 16; i++) expv[i] = 16'h0000;
    run_job(0, 0, 0, 0);

    @(negedge clk);
    b1.start = 1;
    b1.k_len = 3'd1;
    @(negedge clk);
    b1.start = 0;
    b1.x_val = 1;
    b1.x_data = {16'hFF00, 16'h0200};
    b1.w_val = 1;
    b1.w_data = {16'h0300, 16'h0100, 16'h0080};
    b1.out_rdy = 1;
    @(negedge clk);
    b1.x_val = 0;
    b1.w_val = 0;
    n = 0;
    g = 0;
    while (n < 6 && g < 60) begin
      if (b1.out_val) begin
        check("r_data", b1.out_data, e1[n]);
        check("r_row", b1.out_row, n / 3);
        check("r_col", b1.out_col, n % 3);
        check("r_last", b1.out_last, n == 5);
        n++;
      end
      @(negedge clk);
      g++;
    end
    if (n < 6) check("r_timeout", n, 6);
    check("r_idle", b1.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_tile.md
# systolic_tile

Self-sequencing, output-stationary fixed-point systolic matrix-multiply tile computing C[ROWS][COLS] = X[ROWS][K] · W[K][COLS] for runtime K ≤ DEPTH. Successor to the fixed-square systolic datapath:
- rectangular array;
- valid/ready operand streams into per-row and per-column operand FIFOs;
- built-in input skewing and a control FSM;
- a streamed, back-pressured result drain that replaces random-access output selection.

It sits between the accelerator's operand-fetch stage and its writeback stream.

## Interface
- ROWS, 4, array rows (X vector length, C rows); ≥ 1
- COLS, 4, array columns (W vector length, C columns); ≥ 1
- NBITS, 16, operand/accumulator width, two's complement
- DBITS, 8, fractional bits of the fixed-point format; < NBITS
- DEPTH, 16, operand FIFO depth = max K; ≥ 1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a job; sampled only in IDLE
- k_len  in  $clog2(DEPTH+1)  K for the job; sampled with start
- busy  out  1  high in every state except IDLE
- x_val / x_rdy  in / out  1  X-column stream handshake
- x_data  in  ROWS*NBITS  one X column; row i at bits [i*NBITS +: NBITS]
- w_val / w_rdy  in / out  1  W-row stream handshake
- w_data  in  COLS*NBITS  one W row; column j at bits [j*NBITS +: NBITS]
- out_val / out_rdy  out / in  1  result stream handshake
- out_data  out  NBITS  one C element
- out_row  out  $clog2(ROWS) (min 1)  row index of out_data
- out_col  out  $clog2(COLS) (min 1)  column index of out_data
- out_last  out  1  high with the final element of a job

## Operation
- States: IDLE → LOAD → COMPUTE → DRAIN → IDLE.
- IDLE
  - start=1 latches k_len, clears all accumulators and both beat counters.
  - Goes to LOAD; goes straight to DRAIN if k_len=0, which drains all-zero results.
- LOAD
  - x_rdy=1 until k_len X beats have been accepted; w_rdy=1 until k_len W beats have been accepted.
  - The two streams are independent; each may complete in any order or in the same cycle.
  - The FSM moves to COMPUTE in the cycle after both counts reach k_len.
  - Extra beats are not accepted: rdy is low once the count is reached.
- COMPUTE
  - Runs exactly k_len+ROWS+COLS-2 cycles, numbered c = 0…
  - At cycle c, row i's edge input is X[i][c-i] if 0 ≤ c-i < k_len, else 0; row i's FIFO pops at exactly those cycles.
  - At cycle c, column j's edge input is W[c-j][j] under the same rule.
  - Each PE registers x to its right neighbour and w to its lower neighbour, one cycle each.
  - PE(i,j) accumulates X[i][k]·W[k][j] with k = c-i-j.
- DRAIN
  - Emits ROWS*COLS elements in row-major order: (0,0), (0,1), …, (ROWS-1,COLS-1).
  - Each element holds on out_data/out_row/out_col until out_val & out_rdy.
  - out_last accompanies (ROWS-1,COLS-1).
  - The FSM returns to IDLE in the cycle after the last transfer.
- Arithmetic
  - Product is a full 2·NBITS signed value, arithmetic-shifted right by DBITS (truncation toward −∞), then reduced to NBITS.
  - Accumulation is NBITS-wide. Overflow behaviour is set by the Configuration section.
- start outside IDLE is ignored. k_len > DEPTH is clamped to DEPTH.
- Accumulators hold their values after DRAIN until the next start.

## Timing
- Reset values:
  - state=IDLE; busy=0; x_rdy=0; w_rdy=0; out_val=0; out_last=0; out_data=0; out_row=0; out_col=0.
  - All FIFOs empty; all accumulators and PE pipeline registers 0.
- rst in any state aborts the job in that cycle: no partial output, FIFOs flushed.
- x_rdy and w_rdy are registered and rise the cycle after start.
- Latency, start to first out_val, with both streams presenting valid every cycle: 1 + k_len + 1 + (k_len+ROWS+COLS-2) cycles.
- DRAIN with out_rdy held high sustains one element per cycle.
- out_val never drops without a transfer; out_data is stable while out_val & !out_rdy.

## Configuration
- SYSTOLIC_SAT_EN defined:
  - shifted products and accumulations saturate to [−2^(NBITS−1), 2^(NBITS−1)−1];
  - each PE keeps a sticky saturation flag, and the OR of all flags is exported as output `sat` (1 bit, reset 0, cleared on start).
- Not defined: two's-complement wrap modulo 2^NBITS, and no `sat` port.

## Test plan
- Identity, ROWS=COLS=K=4, DBITS=8:
  - stimulus: X = I·1.0 (0x0100), W[k][j] = 0x0100·(4k+j);
  - required: drain emits 0x0000, 0x0100, …, 0x0F00 row-major, out_last on element 15.
- Rectangular, ROWS=2, COLS=3, K=1, X = [2.0, −1.0], W = [0.5, 1.0, 3.0]:
  - required: C = [1.0, 2.0, 6.0, −0.5, −1.0, −3.0], i.e. 0x0100, 0x0200, 0x0600, 0xFF80, 0xFF00, 0xFD00.
- Stream skew:
  - stimulus: X beats all sent before any W beat, with random val gaps;
  - required: results identical to the back-to-back case, and no rdy after k_len beats.
- Back-pressure:
  - stimulus: out_rdy toggled at random during DRAIN;
  - required: every element transferred once, in order, stable while stalled; start during DRAIN is ignored.
- Overflow, K=2, X = W = 127.0 (0x7F00):
  - with SYSTOLIC_SAT_EN: out = 0x7FFF, sat=1;
  - without it: wrapped value 0x0200.
- Reset and edge cases:
  - stimulus: rst asserted mid-COMPUTE, then a new job with k_len=0;
  - required: outputs at reset values the next cycle, then ROWS*COLS zero results.
